// File: rtl/stream_word_packer_if.sv
// Byte-in / word-out bundle for stream_word_packer.
interface stream_word_packer_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        frame_done;
  logic        frame_err;
  logic        overflow;
  logic        busy;

  // byte_valid is a strobe with no backpressure; a word transfers on a rising
  // clock edge where word_valid && word_ready, and word_out must hold while
  // word_valid is high and word_ready is low.
  modport master (
    output byte_in, byte_valid, word_ready,
    input  word_out, word_valid, frame_done, frame_err, overflow, busy
  );

  modport slave (
    input  byte_in, byte_valid, word_ready,
    output word_out, word_valid, frame_done, frame_err, overflow, busy
  );
endinterface

// File: rtl/stream_word_packer.sv
// Sync-hunting byte framer packing payload into 32-bit words behind a small FIFO.
// Optional trailing XOR checksum byte enabled by defining STREAM_PACKER_CHECKSUM_EN.
module stream_word_packer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         OUT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_word_packer_if.slave  bus,
  output logic [1:0]           o_dbg_state
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(OUT_DEPTH);

`ifdef STREAM_PACKER_CHECKSUM_EN
  typedef enum logic [1:0] {S_HUNT = 2'd0, S_LEN = 2'd1, S_PAYLOAD = 2'd2, S_CHK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_HUNT = 2'd0, S_LEN = 2'd1, S_PAYLOAD = 2'd2} state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_lane, w_lane_nxt;
  logic [7:0]  r_wcnt, w_wcnt_nxt;
  logic [23:0] r_asm, w_asm_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        w_push;
  logic [31:0] w_word;

  logic [31:0]   r_mem [OUT_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_ovf;
  logic          w_full, w_empty, w_pop, w_wr;

`ifdef STREAM_PACKER_CHECKSUM_EN
  logic [7:0] r_acc, w_acc_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_wcnt_nxt  = r_wcnt;
    w_asm_nxt   = r_asm;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_push      = 1'b0;
    w_word      = {bus.byte_in, r_asm};
`ifdef STREAM_PACKER_CHECKSUM_EN
    w_acc_nxt   = r_acc;
`endif
    if (bus.byte_valid) begin
      case (r_state)
        S_HUNT: if (bus.byte_in == SYNC_BYTE) w_state_nxt = S_LEN;
        S_LEN: begin
          if (bus.byte_in == 8'd0) begin
            w_state_nxt = S_HUNT;
          end else begin
            w_wcnt_nxt  = bus.byte_in;
            w_lane_nxt  = 2'd0;
            w_state_nxt = S_PAYLOAD;
`ifdef STREAM_PACKER_CHECKSUM_EN
            w_acc_nxt   = 8'd0;
`endif
          end
        end
        S_PAYLOAD: begin
`ifdef STREAM_PACKER_CHECKSUM_EN
          w_acc_nxt  = r_acc ^ bus.byte_in;
`endif
          w_lane_nxt = r_lane + 2'd1;
          // Little-endian: lane 0 lands in [7:0]; lane 3 completes the word.
          case (r_lane)
            2'd0: w_asm_nxt[7:0]   = bus.byte_in;
            2'd1: w_asm_nxt[15:8]  = bus.byte_in;
            2'd2: w_asm_nxt[23:16] = bus.byte_in;
            default: begin
              w_push     = 1'b1;
              w_wcnt_nxt = r_wcnt - 8'd1;
              if (r_wcnt == 8'd1) begin
`ifdef STREAM_PACKER_CHECKSUM_EN
                w_state_nxt = S_CHK;
`else
                w_state_nxt = S_HUNT;
                w_done_nxt  = 1'b1;
`endif
              end
            end
          endcase
        end
`ifdef STREAM_PACKER_CHECKSUM_EN
        S_CHK: begin
          w_state_nxt = S_HUNT;
          if (bus.byte_in == r_acc) w_done_nxt = 1'b1;
          else                      w_err_nxt  = 1'b1;
        end
`endif
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HUNT;
      r_lane  <= 2'd0;
      r_wcnt  <= 8'd0;
      r_asm   <= 24'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_asm   <= w_asm_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

`ifdef STREAM_PACKER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= 8'd0;
    else        r_acc <= w_acc_nxt;
  end
`endif

  // A pop frees the head slot on the same edge, so a push into a full FIFO
  // with a concurrent pop is accepted.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.word_ready;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) r_mem[i] <= 32'd0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      if (w_push && !w_wr) r_ovf <= 1'b1;
    end
  end

  assign bus.word_out   = r_mem[r_rd_ptr];
  assign bus.word_valid = !w_empty;
  assign bus.frame_done = r_done;
  assign bus.frame_err  = r_err;
  assign bus.overflow   = r_ovf;
  assign bus.busy       = (r_state != S_HUNT);
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_stream_word_packer.sv
// Self-checking bench for stream_word_packer: frame-level reference model plus directed cases.
`timescale 1ns/1ps
module tb_stream_word_packer;
  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  stream_word_packer_if bus();

  stream_word_packer #(.SYNC_BYTE(SYNC), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [31:0] exp_q[$];
  logic [7:0]  m_bytes[$];
  int          m_mode = 0;        // 0 hunting, 1 length byte, 2 payload, 3 checksum byte
  int          m_words_left = 0;
  logic [7:0]  m_xor = 8'd0;
  bit          m_ovf = 0, m_done = 0, m_err = 0;
  bit          m_pop, m_full, m_have;
  logic [31:0] m_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_bytes.delete();
      m_mode = 0; m_words_left = 0; m_xor = 8'd0;
      m_ovf = 0; m_done = 0; m_err = 0;
    end else begin
      m_pop  = (exp_q.size() > 0) && bus.word_ready;
      m_full = (exp_q.size() == DEPTH);
      m_have = 0; m_done = 0; m_err = 0; m_w = 32'd0;
      if (bus.byte_valid) begin
        case (m_mode)
          0: if (bus.byte_in == SYNC) m_mode = 1;
          1: begin
            if (bus.byte_in == 8'd0) m_mode = 0;
            else begin
              m_words_left = int'(bus.byte_in);
              m_bytes.delete(); m_xor = 8'd0; m_mode = 2;
            end
          end
          2: begin
            m_bytes.push_back(bus.byte_in);
            m_xor = m_xor ^ bus.byte_in;
            if (m_bytes.size() == 4) begin
              m_w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
              m_have = 1;
              m_bytes.delete();
              m_words_left--;
              if (m_words_left == 0) begin
`ifdef STREAM_PACKER_CHECKSUM_EN
                m_mode = 3;
`else
                m_mode = 0; m_done = 1;
`endif
              end
            end
          end
          default: begin
            if (bus.byte_in == m_xor) m_done = 1;
            else m_err = 1;
            m_mode = 0;
          end
        endcase
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_have) begin
        if (m_full && !m_pop) m_ovf = 1;
        else exp_q.push_back(m_w);
      end
    end
  end

  // ---------------- scoreboard compare + monitor ----------------
  logic [31:0] got_q[$];
  int done_cnt = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check32("word_valid", {31'd0, bus.word_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) check32("word_out", bus.word_out, exp_q[0]);
      check32("overflow",   {31'd0, bus.overflow},   {31'd0, m_ovf});
      check32("frame_done", {31'd0, bus.frame_done}, {31'd0, m_done});
      check32("frame_err",  {31'd0, bus.frame_err},  {31'd0, m_err});
      check32("busy",       {31'd0, bus.busy},       {31'd0, m_mode != 0});
      if (bus.word_valid && bus.word_ready) got_q.push_back(bus.word_out);
      if (bus.frame_done) done_cnt++;
      if (bus.frame_err)  err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] bq[$];
  bit         rand_ready = 0;

  task automatic send(input logic [7:0] b, input bit v);
    @(posedge clk); #1;
    bus.byte_in    = b;
    bus.byte_valid = v;
    if (rand_ready) bus.word_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_q(input bit gap);
    foreach (bq[i]) begin
      send(bq[i], 1'b1);
      if (gap) send(8'($urandom), 1'b0);
    end
  endtask

  task automatic send_chk(input logic [7:0] c);
`ifdef STREAM_PACKER_CHECKSUM_EN
    send(c, 1'b1);
`else
    c = c;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) send(8'($urandom), 1'b0);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    bus.word_ready = r;
  endtask

  task automatic clear_obs();
    got_q.delete(); done_cnt = 0; err_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.byte_valid = 1'b0;
    bus.word_ready = 1'b0;
    #1;
    check32("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    check32("rst_word_out",   bus.word_out,            32'd0);
    check32("rst_busy",       {31'd0, bus.busy},       32'd0);
    check32("rst_overflow",   {31'd0, bus.overflow},   32'd0);
    check32("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    check32("rst_frame_err",  {31'd0, bus.frame_err},  32'd0);
    check32("rst_state",      {30'd0, dbg_state},      32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    set_ready(1'b1);
    while ((exp_q.size() != 0 || bus.word_valid) && k < 60) begin
      @(posedge clk); #1; k++;
    end
    check32("drain_bound", {31'd0, k < 60}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int glen;
  logic [7:0] b, x;

  initial begin
    bus.byte_in = 8'd0; bus.byte_valid = 1'b0; bus.word_ready = 1'b0;
    do_reset();

    // Two-word frame, continuous bytes
    clear_obs(); set_ready(1'b1);
    bq = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_q(0); send_chk(8'h88); idle(4);
    check32("t1_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check32("t1_w0", got_q[0], 32'h44332211);
      check32("t1_w1", got_q[1], 32'h88776655);
    end
    check32("t1_done_cnt", done_cnt, 1);
    check32("t1_busy_low", {31'd0, bus.busy}, 32'd0);

    // Garbage then frame, gapped strobes
    clear_obs();
    bq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_q(1); send_chk(8'h22); idle(4);
    check32("t2_count", got_q.size(), 1);
    if (got_q.size() == 1) check32("t2_w0", got_q[0], 32'hEFBEADDE);

    // Zero-length frame rejected
    clear_obs();
    bq = '{8'hA5, 8'h00, 8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    send_q(0); send_chk(8'h04); idle(4);
    check32("t3_count", got_q.size(), 1);
    if (got_q.size() == 1) check32("t3_w0", got_q[0], 32'h04030201);
    check32("t3_done_cnt", done_cnt, 1);

    // Overflow: five words, consumer stalled
    clear_obs(); set_ready(1'b0);
    bq = '{8'hA5, 8'h05};
    send_q(0);
    for (int i = 1; i <= 20; i++) send(8'(i), 1'b1);
    send_chk(8'h14); idle(3);
    check32("t4_overflow", {31'd0, bus.overflow}, 32'd1);
    check32("t4_valid", {31'd0, bus.word_valid}, 32'd1);
    set_ready(1'b1); idle(8);
    check32("t4_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check32("t4_w0", got_q[0], 32'h04030201);
      check32("t4_w3", got_q[3], 32'h100F0E0D);
    end
    check32("t4_sticky", {31'd0, bus.overflow}, 32'd1);
    do_reset();

    // Push into full FIFO with concurrent pop
    clear_obs(); set_ready(1'b0);
    bq = '{8'hA5, 8'h04};
    send_q(0);
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b1);
    send_chk(8'h10); idle(2);
    bq = '{8'hA5, 8'h01, 8'h21, 8'h22, 8'h23};
    send_q(0);
    @(posedge clk); #1; bus.word_ready = 1'b1; bus.byte_in = 8'h24; bus.byte_valid = 1'b1;
    @(posedge clk); #1; bus.word_ready = 1'b0; bus.byte_valid = 1'b0;
    check32("t5_overflow", {31'd0, bus.overflow}, 32'd0);
    check32("t5_head", bus.word_out, 32'h08070605);
    send_chk(8'h04);
    drain();
    check32("t5_count", got_q.size(), 5);
    if (got_q.size() == 5) check32("t5_w4", got_q[4], 32'h24232221);

`ifdef STREAM_PACKER_CHECKSUM_EN
    // Checksum good then bad
    clear_obs();
    bq = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_q(0); idle(3);
    check32("t6_done", done_cnt, 1);
    check32("t6_err0", err_cnt, 0);
    clear_obs();
    bq = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_q(0); idle(3);
    check32("t6_err", err_cnt, 1);
    check32("t6_nodone", done_cnt, 0);
    check32("t6_word", got_q.size(), 1);
`endif

    // Reset mid-frame
    clear_obs(); set_ready(1'b0);
    bq = '{8'hA5, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_q(0); send_chk(8'h00);
    bq = '{8'hA5, 8'h02, 8'h11, 8'h22};
    send_q(0);
    do_reset();
    clear_obs(); set_ready(1'b1);
    bq = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    send_q(0); send_chk(8'h04); idle(4);
    check32("t7_count", got_q.size(), 1);
    if (got_q.size() == 1) check32("t7_w0", got_q[0], 32'h04030201);

    // Randomized frames with gaps, random backpressure and garbage
    rand_ready = 1;
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        send(b, 1'b1);
      end
      send(SYNC, 1'b1);
      glen = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      send(8'(glen), 1'b1);
      x = 8'd0;
      for (int i = 0; i < glen * 4; i++) begin
        if ($urandom_range(0, 3) == 0) send(8'($urandom), 1'b0);
        b = 8'($urandom);
        x = x ^ b;
        send(b, 1'b1);
      end
      if (glen != 0) send_chk(($urandom_range(0, 3) == 0) ? 8'($urandom) : x);
    end
    rand_ready = 0;
    idle(2);
    drain();
    check32("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/stream_word_packer.md
Name: stream_word_packer

Overview:
- Downstream consumer of the 4-tap byte delay line: takes the selected-tap byte stream (one byte per qualified clock, no backpressure available upstream) and frames it.
- Hunts for a sync byte, reads a length byte, packs payload bytes into 32-bit words and queues them in a small output FIFO with a valid/ready handshake toward the host-side logic.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker searched for in HUNT
OUT_DEPTH, 4, output word FIFO depth; power of two, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
byte_in  in  8  byte from delay-line tap output
byte_valid  in  1  byte_in is a new byte this cycle; cannot be stalled
word_out  out  32  head-of-FIFO word
word_valid  out  1  FIFO not empty
word_ready  in  1  consumer accepts word_out this cycle
frame_done  out  1  one-cycle pulse, frame completed
frame_err  out  1  one-cycle pulse, frame checksum mismatch (CHECKSUM_EN only)
overflow  out  1  sticky: a completed word was dropped because FIFO was full
busy  out  1  high whenever state != HUNT

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=HUNT, FIFO empty, word_valid=0, word_out=0, frame_done=0, frame_err=0, overflow=0, busy=0, byte counter=0, word counter=0.
- Bytes are consumed only on cycles with byte_valid=1; byte_valid=0 cycles change nothing in the framer.
- FSM:
  - HUNT: byte==SYNC_BYTE -> LEN; else stay.
  - LEN: byte==0 -> HUNT (empty frame rejected, no pulse); else load word counter with byte (1..255), clear byte lane index, go to PAYLOAD.
  - PAYLOAD: little-endian packing, first byte of each group to [7:0], 4th to [31:24]. On the 4th byte the assembled word is pushed, lane index wraps to 0, word counter decrements. Push of the last word -> HUNT (or CHK with CHECKSUM_EN); frame_done pulses the cycle after the last push (without CHECKSUM_EN).
  - A SYNC_BYTE value inside LEN/PAYLOAD is data, never a resync.
- FIFO:
  - Push happens on the clock edge accepting the 4th byte.
  - word_valid rises the following cycle; the head is registered, so there is no combinational path from byte_in to word_out.
  - Pop on word_valid & word_ready. Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push while full without pop: word dropped, overflow set, framing continues (counters still advance).
  - Pop when empty: ignored.
  - Pointers are log2(OUT_DEPTH) bits and wrap naturally; full/empty use a separate count of log2(OUT_DEPTH)+1 bits.
- overflow clears only on reset.
- Reset mid-frame: partial word discarded, FIFO flushed, back to HUNT.

Optional Feature:
- Macro STREAM_PACKER_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator is cleared in LEN and folds every payload byte.
  - After the last word, state CHK consumes one more byte. If it equals the accumulator: frame_done pulses. If not: frame_err pulses and frame_done does not. Either way the FSM returns to HUNT.
  - Words already pushed are not retracted.
- Undefined: no CHK state, no accumulator, frame_err tied 0.

Test Plan:
- Reset, then stream A5,02,11,22,33,44,55,66,77,88 with byte_valid=1 and word_ready=1 -> words 44332211 then 88776655; frame_done pulses once; busy falls after the last byte.
- Garbage 00,FF,5A before A5,01,DE,AD,BE,EF, with byte_valid gapped every other cycle -> single word EFBEADDE; garbage bytes ignored.
- Length 0: A5,00 then A5,01,01,02,03,04 -> no output for the first frame, word 04030201 for the second.
- word_ready=0, frame length 5 with OUT_DEPTH=4 -> 4 words held, 5th dropped, overflow=1 and stays 1. Then word_ready=1 -> the 4 held words drain in order.
- FIFO full with word_ready=1 on the same cycle as a push -> no drop, overflow stays 0, count stays 4.
- CHECKSUM_EN: A5,01,01,02,03,04,04 -> frame_done. Same frame with trailing 05 -> frame_err, no frame_done, word 04030201 still delivered.
- rst_n low after 2 payload bytes -> all outputs return to reset values immediately. The next full frame decodes correctly.
